// File: rtl/register_file_sb_pkg.sv
// Shared CPU datapath types and default geometry for the register file slice.
package register_file_sb_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NREGS   = 32;
    localparam int DEF_NRPORTS = 2;
    localparam int DEF_NWPORTS = 2;
    localparam int DEF_PEND_W  = 2;
    localparam int REG_IDX_W   = $clog2(DEF_NREGS);

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [REG_IDX_W-1:0]  regbits_t;
    typedef logic [DEF_PEND_W-1:0] pend_t;

    localparam pend_t PEND_MAX = '1;

    // Bits needed to count 0..n simultaneous events.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/register_file_sb_if.sv
// Issue/writeback bus of the register file: read ports, write ports, reservation and flush.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NREGS   = DEF_NREGS,
    parameter int NRPORTS = DEF_NRPORTS,
    parameter int NWPORTS = DEF_NWPORTS
);
    localparam int SEL_W = $clog2(NREGS);

    logic [NRPORTS-1:0][SEL_W-1:0]  rsel;
    logic [NRPORTS-1:0][DATA_W-1:0] rdat;
    logic [NRPORTS-1:0]             rbusy;
    logic [NWPORTS-1:0]             wen;
    logic [NWPORTS-1:0][SEL_W-1:0]  wsel;
    logic [NWPORTS-1:0][DATA_W-1:0] wdat;
    logic                           rsv_en;
    logic [SEL_W-1:0]               rsv_sel;
    logic                           rsv_ok;
    logic                           flush;

    modport master (
        output rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
        input  rdat, rbusy, rsv_ok
    );

    modport slave (
        input  rsel, wen, wsel, wdat, rsv_en, rsv_sel, flush,
        output rdat, rbusy, rsv_ok
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-write scoreboard: per-register in-flight write counters, reservation
// acceptance and busy-operand reporting for the read ports.
module rf_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int NREGS   = DEF_NREGS,
    parameter int NRPORTS = DEF_NRPORTS,
    parameter int NWPORTS = DEF_NWPORTS,
    parameter int PEND_W  = DEF_PEND_W,
    parameter bit BYPASS  = 1'b1,
    localparam int SEL_W  = $clog2(NREGS)
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NRPORTS-1:0][SEL_W-1:0] rsel_i,
    input  logic [NWPORTS-1:0]            wen_i,
    input  logic [NWPORTS-1:0][SEL_W-1:0] wsel_i,
    input  logic                          rsv_en_i,
    input  logic [SEL_W-1:0]              rsv_sel_i,
    input  logic                          flush_i,
    output logic [NRPORTS-1:0]            rbusy_o,
    output logic                          rsv_ok_o
);
    localparam int CNT_W = cnt_width(NWPORTS);
    localparam int SUM_W = ((PEND_W > CNT_W) ? PEND_W : CNT_W) + 1;
    localparam logic [PEND_W-1:0] PEND_LIM = {PEND_W{1'b1}};

    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic [CNT_W-1:0]  dec    [NREGS];
    logic [NREGS-1:0]  inc;

    // Every write port landing on a register retires one reservation, collisions included.
    always_comb begin
        for (int r = 0; r < NREGS; r++) dec[r] = '0;
        for (int p = 0; p < NWPORTS; p++) begin
            if (wen_i[p]) dec[wsel_i[p]] = dec[wsel_i[p]] + CNT_W'(1);
        end
    end

    always_comb begin
        rsv_ok_o = 1'b0;
        inc      = '0;
        if (rsv_en_i && rsv_sel_i != '0) begin
            rsv_ok_o = (pend_q[rsv_sel_i] != PEND_LIM) || (dec[rsv_sel_i] != '0);
        end
        if (rsv_ok_o) inc[rsv_sel_i] = 1'b1;
    end

    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] sub;
        sum = '0;
        sub = '0;
        for (int r = 0; r < NREGS; r++) begin
            sum = SUM_W'(pend_q[r]) + SUM_W'(inc[r]);
            sub = SUM_W'(dec[r]);
            // Unreserved writes are legal, so the count floors at zero instead of wrapping.
            pend_d[r] = (sum > sub) ? PEND_W'(sum - sub) : '0;
            if (flush_i) pend_d[r] = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
        end
    end

    always_comb begin
        rbusy_o = '0;
        for (int i = 0; i < NRPORTS; i++) begin
            if (rsel_i[i] != '0) begin
                if (BYPASS) begin
                    rbusy_o[i] = SUM_W'(pend_q[rsel_i[i]]) > SUM_W'(dec[rsel_i[i]]);
                end else begin
                    rbusy_o[i] = pend_q[rsel_i[i]] != '0;
                end
            end
        end
    end
endmodule

// File: rtl/register_file_sb.sv
// Multi-port general-purpose register file with optional write-to-read bypass.
// Holds the data array and write priority; pending-write tracking lives in rf_scoreboard.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NREGS   = DEF_NREGS,
    parameter int NRPORTS = DEF_NRPORTS,
    parameter int NWPORTS = DEF_NWPORTS,
    parameter int PEND_W  = DEF_PEND_W,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    register_file_sb_if.slave bus
);
    logic [DATA_W-1:0] regs_q  [NREGS];
    logic [DATA_W-1:0] regs_d  [NREGS];
    logic [DATA_W-1:0] wr_data [NREGS];
    logic [NREGS-1:0]  wr_hit;

    // NOTE: combinational blocks use blocking '=' and assign every output a default
    // before any conditional update, so no path leaves a value held (no latch).
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) wr_data[r] = '0;
        // Ascending scan: the highest-index colliding port overwrites the lower ones.
        for (int p = 0; p < NWPORTS; p++) begin
            if (bus.wen[p] && bus.wsel[p] != '0) begin
                wr_hit[bus.wsel[p]]  = 1'b1;
                wr_data[bus.wsel[p]] = bus.wdat[p];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = wr_hit[r] ? wr_data[r] : regs_q[r];
        end
    end

    // NOTE: the data array is reset with the rest of the state because a freshly
    // reset register must read as zero; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    always_comb begin
        bus.rdat = '0;
        for (int i = 0; i < NRPORTS; i++) begin
            bus.rdat[i] = regs_q[bus.rsel[i]];
            if (BYPASS && wr_hit[bus.rsel[i]]) bus.rdat[i] = wr_data[bus.rsel[i]];
        end
    end

    rf_scoreboard #(
        .NREGS   (NREGS),
        .NRPORTS (NRPORTS),
        .NWPORTS (NWPORTS),
        .PEND_W  (PEND_W),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .CLK       (CLK),
        .nRST      (nRST),
        .rsel_i    (bus.rsel),
        .wen_i     (bus.wen),
        .wsel_i    (bus.wsel),
        .rsv_en_i  (bus.rsv_en),
        .rsv_sel_i (bus.rsv_sel),
        .flush_i   (bus.flush),
        .rbusy_o   (bus.rbusy),
        .rsv_ok_o  (bus.rsv_ok)
    );
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised multi-port general-purpose register file for the CPU datapath.
- Generalises the single-write/dual-read file to NWPORTS write ports and NRPORTS read ports, with optional same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard: issue logic reserves a destination register, writeback releases it, and read ports report busy operands.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register data width.
- NREGS, 32, number of registers; power of two, at least 2.
- NRPORTS, 2, number of read ports.
- NWPORTS, 2, number of write ports.
- PEND_W, 2, width of the per-register pending-write counter; maximum in-flight writes per register is 2^PEND_W-1.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored state only.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  asynchronous active-low reset.
- rsel  in  NRPORTS x $clog2(NREGS)  read selects.
- rdat  out  NRPORTS x DATA_W  read data.
- rbusy  out  NRPORTS  selected register has outstanding reserved writes.
- wen  in  NWPORTS  write enables.
- wsel  in  NWPORTS x $clog2(NREGS)  write selects.
- wdat  in  NWPORTS x DATA_W  write data.
- rsv_en  in  1  reserve request for rsv_sel (issue of a register-writing instruction).
- rsv_sel  in  $clog2(NREGS)  register to reserve.
- rsv_ok  out  1  combinational; reservation accepted this cycle.
- flush  in  1  clear all pending counters; data is untouched.

Behaviour:
- Reset (async, nRST=0): all registers 0 and all pending counters 0. Outputs settle combinationally to: rdat=0, rbusy=0, rsv_ok=rsv_en&&(rsv_sel!=0).
- Register 0:
  - Reads always return 0 and rbusy is always 0.
  - Writes to register 0 are ignored.
  - Reservations of register 0 are ignored; rsv_ok=0 for rsv_sel=0.
- Writes, posedge:
  - For each register r!=0, if any port p has wen[p]&&wsel[p]==r, r takes wdat of the highest-index such port.
  - Lower-index colliding writes are dropped.
- Read data:
  - rdat[i] = reg[rsel[i]] combinationally, zero-latency.
  - If BYPASS=1 and some port writes rsel[i] (non-zero) this cycle, rdat[i] returns that cycle's winning wdat.
- Pending counter, per register r, posedge:
  - next = pend[r] + inc - dec.
  - inc = rsv_en&&rsv_ok&&rsv_sel==r.
  - dec = number of write ports with wen&&wsel==r. Every colliding write consumes one reservation.
  - Underflow clamps at 0: writes without a reservation are legal and do not error.
- rsv_ok:
  - rsv_ok = rsv_en && rsv_sel!=0 && (pend[rsv_sel] < max || a write to rsv_sel occurs this cycle).
  - Denial leaves state unchanged; issue must stall and retry.
- rbusy[i]:
  - BYPASS=1: (pend[rsel[i]] - dec[rsel[i]], floored at 0) != 0.
  - BYPASS=0: pend[rsel[i]] != 0.
  - Same-cycle reservations do not affect rbusy.
- Simultaneous reserve and write to the same register: both apply. Net counter is unchanged when one write lands.
- flush:
  - Counters go to 0 at posedge. Reservations and writes in the same cycle are discarded from the counters.
  - Register writes in that cycle still commit.
- Reset mid-operation: immediate clear of data and counters regardless of clock; no write or reservation survives.

Decomposition:
- Shared cpu_types package: regbits_t (register index) and word_t, already present; add pend_t (logic [PEND_W-1:0]) and constant PEND_MAX.
- One natural sub-module: rf_scoreboard. It contains the pending counters, rsv_ok, the dec counting and rbusy. The top level keeps the data array, write priority and bypass muxing.

Test Plan:
- Reset: write reg5=0xDEADBEEF, assert nRST=0 between edges -> rdat for rsel=5 reads 0 immediately; rbusy=0.
- Write collision: port0 writes r7=0x11, port1 writes r7=0x22 same cycle -> r7=0x22; pend[7] drops by 2 from 2 to 0.
- Bypass: BYPASS=1, r3=0xA, port0 writes r3=0xB, rsel0=3 same cycle -> rdat0=0xB and rbusy0=0 (pend[3] was 1). With BYPASS=0 -> rdat0=0xA, rbusy0=1.
- Scoreboard saturation: PEND_W=2, reserve r9 three times -> rsv_ok=1 each time, pend=3. 4th reserve -> rsv_ok=0. 4th reserve with a simultaneous r9 write -> rsv_ok=1, pend stays 3.
- Zero register: reserve r0 and write r0=0xFFFF -> rsv_ok=0, rdat=0, rbusy=0.
- Flush: pend[4]=2, flush with port0 writing r4=0x5 and rsv_en on r4 -> pend[4]=0 next cycle, r4=0x5.
